// File: rtl/occ_gt_pattern_pkg.sv
// ---------------------------------------------------------------------------
// occ_gt_pattern_pkg
// Shared definitions for the OCC transceiver test pattern (generator and
// checker): comma word / K flags, frame geometry and checker state encoding.
// Frame: one K28.5 comma word followed by 31 incrementing counter words.
// ---------------------------------------------------------------------------
package occ_gt_pattern_pkg;

  localparam logic [15:0] COMMA_WORD    = 16'hBC95;
  localparam logic [1:0]  COMMA_CHARISK = 2'b10;
  localparam int unsigned FRAME_LEN     = 32;
  localparam int unsigned FRAME_LOG2    = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // True when the received word is a clean comma (no code errors).
  function automatic logic is_comma(
    input logic [15:0] data,
    input logic [1:0]  charisk,
    input logic [1:0]  disperr,
    input logic [1:0]  notintable
  );
    return (data == COMMA_WORD) && (charisk == COMMA_CHARISK) &&
           (disperr == 2'b00) && (notintable == 2'b00);
  endfunction

endpackage

// File: rtl/occ_sat_counter.sv
// ---------------------------------------------------------------------------
// occ_sat_counter
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   clear_i  synchronous clear to zero
//   inc_i    increment request; ignored once the count is all-ones
//   cnt_o    current count (registered)
// ---------------------------------------------------------------------------
module occ_sat_counter #(
  parameter int unsigned g_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [g_WIDTH-1:0] cnt_o
);

  logic [g_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/occ_gt_pattern_check.sv
// ---------------------------------------------------------------------------
// occ_gt_pattern_check
// Receive-side checker for the OCC transceiver test pattern. Acquires frame
// alignment on the comma, tracks the counter, reports lock, per-word error
// pulses and saturating error / checked-word counts.
// Ports:
//   clk_i           transceiver user clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   clear_i         synchronous clear of err_cnt_o / word_cnt_o (FSM unaffected)
//   valid_i         word qualifier; low = word ignored, all state held
//   rxdata_i        received word, [15:8] upper byte
//   rxcharisk_i     K flags, bit 1 pairs with rxdata_i[15:8]
//   rxdisperr_i     disparity error flags
//   rxnotintable_i  not-in-table flags
//   lock_o          pattern locked
//   err_o           one-cycle pulse per bad word while locked
//   err_cnt_o       saturating count of bad words while locked
//   word_cnt_o      saturating count of words checked while locked
// ---------------------------------------------------------------------------
module occ_gt_pattern_check
  import occ_gt_pattern_pkg::*;
#(
  parameter int unsigned g_LOSS_THRESH = 4,
  parameter int unsigned g_CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [15:0]            rxdata_i,
  input  logic [1:0]             rxcharisk_i,
  input  logic [1:0]             rxdisperr_i,
  input  logic [1:0]             rxnotintable_i,
  output logic                   lock_o,
  output logic                   err_o,
  output logic [g_CNT_WIDTH-1:0] err_cnt_o,
  output logic [g_CNT_WIDTH-1:0] word_cnt_o
);

  state_t      r_state;
  logic [15:0] r_exp;
  logic [3:0]  r_bad_run;
  logic        r_lock;
  logic        r_err;

  logic w_code_ok;
  logic w_comma;
  logic w_data_ok;
  logic w_slot_comma;
  logic w_good;
  logic w_lock_eval;
  logic w_bad;
  logic w_sync_ok;

  assign w_code_ok    = (rxdisperr_i == 2'b00) && (rxnotintable_i == 2'b00);
  assign w_comma      = is_comma(rxdata_i, rxcharisk_i, rxdisperr_i, rxnotintable_i);
  assign w_data_ok    = (rxcharisk_i == 2'b00) && w_code_ok && (rxdata_i == r_exp);
  // The comma occupies the counter slot whose low frame bits are zero.
  assign w_slot_comma = (r_exp[FRAME_LOG2-1:0] == '0);
  assign w_good       = w_slot_comma ? w_comma : w_data_ok;
  assign w_lock_eval  = valid_i && (r_state == ST_LOCKED);
  assign w_bad        = w_lock_eval && !w_good;
  assign w_sync_ok    = (rxcharisk_i == 2'b00) && w_code_ok &&
                        (rxdata_i[FRAME_LOG2-1:0] == FRAME_LOG2'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_HUNT;
      r_exp     <= '0;
      r_bad_run <= '0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (valid_i) begin
        case (r_state)
          ST_HUNT: begin
            if (w_comma) begin
              r_state <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (w_sync_ok) begin
              r_exp   <= rxdata_i + 16'd1;
              r_state <= ST_LOCKED;
              r_lock  <= 1'b1;
            end else begin
              r_state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // Expected value advances whatever the outcome so a single
            // corrupted word does not shift the frame.
            r_exp <= r_exp + 16'd1;
            if (w_good) begin
              r_bad_run <= '0;
            end else if (r_bad_run == 4'(g_LOSS_THRESH - 1)) begin
              r_bad_run <= '0;
              r_state   <= ST_HUNT;
              r_lock    <= 1'b0;
            end else begin
              r_bad_run <= r_bad_run + 4'd1;
            end
          end
          default: begin
            r_state   <= ST_HUNT;
            r_bad_run <= '0;
            r_lock    <= 1'b0;
          end
        endcase
      end
    end
  end

  occ_sat_counter #(
    .g_WIDTH (g_CNT_WIDTH)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear_i),
    .inc_i   (w_bad),
    .cnt_o   (err_cnt_o)
  );

  occ_sat_counter #(
    .g_WIDTH (g_CNT_WIDTH)
  ) u_word_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear_i),
    .inc_i   (w_lock_eval),
    .cnt_o   (word_cnt_o)
  );

  assign lock_o = r_lock;
  assign err_o  = r_err;

endmodule

// File: tb/tb_occ_gt_pattern_check.sv
// ---------------------------------------------------------------------------
// tb_occ_gt_pattern_check
// Directed bench: main instance (threshold 4, 32-bit counts) and a small
// instance (threshold 15, 4-bit counts) for saturation, sharing stimulus.
// ---------------------------------------------------------------------------
module tb_occ_gt_pattern_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] rxdata = '0;
  logic [1:0]  rxk = '0;
  logic [1:0]  rxde = '0;
  logic [1:0]  rxnit = '0;

  logic        lock, err;
  logic [31:0] err_cnt, word_cnt;
  logic        s_lock, s_err;
  logic [3:0]  s_err_cnt, s_word_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  occ_gt_pattern_check #(
    .g_LOSS_THRESH (4),
    .g_CNT_WIDTH   (32)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clear_i        (clear),
    .valid_i        (valid),
    .rxdata_i       (rxdata),
    .rxcharisk_i    (rxk),
    .rxdisperr_i    (rxde),
    .rxnotintable_i (rxnit),
    .lock_o         (lock),
    .err_o          (err),
    .err_cnt_o      (err_cnt),
    .word_cnt_o     (word_cnt)
  );

  occ_gt_pattern_check #(
    .g_LOSS_THRESH (15),
    .g_CNT_WIDTH   (4)
  ) dut_sat (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clear_i        (clear),
    .valid_i        (valid),
    .rxdata_i       (rxdata),
    .rxcharisk_i    (rxk),
    .rxdisperr_i    (rxde),
    .rxnotintable_i (rxnit),
    .lock_o         (s_lock),
    .err_o          (s_err),
    .err_cnt_o      (s_err_cnt),
    .word_cnt_o     (s_word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word, clock it in, return 1 time unit after the edge.
  task automatic send(input logic [15:0] d, input logic [1:0] k,
                      input logic [1:0] de, input logic [1:0] nit, input logic v);
    rxdata = d; rxk = k; rxde = de; rxnit = nit; valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_d(input logic [15:0] d);
    send(d, 2'b00, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic send_c();
    send(16'hBC95, 2'b10, 2'b00, 2'b00, 1'b1);
  endtask

  initial begin
    // reset
    #12;
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean acquisition
    send_c();
    chk("sync_nolock", 32'(lock), 32'd0);
    send_d(16'h0001);
    chk("lock_after_sync", 32'(lock), 32'd1);
    chk("sync_word_not_counted", word_cnt, 32'd0);
    for (int i = 2; i <= 31; i++) send_d(16'(i));
    send_c();
    for (int i = 33; i <= 36; i++) send_d(16'(i));
    chk("clean_word_cnt", word_cnt, 32'd35);
    chk("clean_err_cnt", err_cnt, 32'd0);

    // single corruption
    send_d(16'h0125);
    chk("corrupt_err_pulse", 32'(err), 32'd1);
    chk("corrupt_err_cnt", err_cnt, 32'd1);
    chk("corrupt_lock", 32'(lock), 32'd1);
    send_d(16'h0026);
    chk("corrupt_err_clears", 32'(err), 32'd0);
    chk("corrupt_exp_continues", err_cnt, 32'd1);
    chk("corrupt_word_cnt", word_cnt, 32'd37);

    // loss of lock after 4 consecutive bad words
    for (int i = 16'h27; i <= 16'h3F; i++) send_d(16'(i));
    send(16'hBC95, 2'b10, 2'b01, 2'b00, 1'b1);
    send_d(16'hDEAD);
    send_d(16'h0000);
    chk("loss_3rd_still_locked", 32'(lock), 32'd1);
    send_d(16'h0000);
    chk("loss_4th_unlocked", 32'(lock), 32'd0);
    chk("loss_4th_err", 32'(err), 32'd1);
    chk("loss_err_cnt", err_cnt, 32'd5);
    chk("loss_word_cnt", word_cnt, 32'd66);
    send_d(16'h0024);
    send_c();
    send_d(16'hFFE1);
    chk("reacq_lock", 32'(lock), 32'd1);

    // 16-bit wrap, comma expected at exp 0x0000
    for (int i = 16'hFFE2; i <= 16'hFFFF; i++) send_d(16'(i));
    send_c();
    for (int i = 1; i <= 4; i++) send_d(16'(i));
    chk("wrap_err_cnt", err_cnt, 32'd5);
    chk("wrap_word_cnt", word_cnt, 32'd101);
    chk("wrap_lock", 32'(lock), 32'd1);

    // valid low holds everything
    for (int i = 0; i < 10; i++) send(16'hFFFF, 2'b11, 2'b11, 2'b11, 1'b0);
    chk("hold_err", 32'(err), 32'd0);
    chk("hold_word_cnt", word_cnt, 32'd101);
    chk("hold_err_cnt", err_cnt, 32'd5);
    send_d(16'h0005);
    chk("hold_resume_err", 32'(err), 32'd0);
    chk("hold_resume_word_cnt", word_cnt, 32'd102);

    // async reset mid-frame while err_o is high
    send_d(16'h1234);
    chk("pre_rst_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_lock", 32'(lock), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_err_cnt", err_cnt, 32'd0);
    chk("async_rst_word_cnt", word_cnt, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // bad SYNC word returns to HUNT without counting
    send_c();
    send_d(16'h0003);
    chk("badsync_lock", 32'(lock), 32'd0);
    chk("badsync_err", 32'(err), 32'd0);
    send_d(16'h0004);
    chk("badsync_err_cnt", err_cnt, 32'd0);

    // saturation on the 4-bit instance (threshold 15)
    send_c();
    send_d(16'h0001);
    chk("sat_lock", 32'(s_lock), 32'd1);
    for (int i = 0; i < 10; i++) send_d(16'hFFFF);
    send_d(16'h000C);
    for (int i = 0; i < 10; i++) send_d(16'hFFFF);
    chk("sat_err_cnt", 32'(s_err_cnt), 32'hF);
    chk("sat_word_cnt", 32'(s_word_cnt), 32'hF);
    chk("sat_still_locked", 32'(s_lock), 32'd1);
    clear = 1'b1;
    send_d(16'hFFFF);
    clear = 1'b0;
    chk("clear_err_cnt", 32'(s_err_cnt), 32'd0);
    chk("clear_word_cnt", 32'(s_word_cnt), 32'd0);
    chk("clear_err_pulse", 32'(s_err), 32'd1);
    send_d(16'h0018);
    chk("after_clear_word_cnt", 32'(s_word_cnt), 32'd1);
    chk("after_clear_err_cnt", 32'(s_err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
